// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle control sequencer for the 8-bit, 4-register CPU datapath.
// It owns the program counter, the instruction register and the immediate
// register. Each instruction is stepped through:
//
//     FETCH -> [FETCH_IMM] -> EXECUTE -> [MEM] -> [WRITEBACK]
//
// Register-file, data-memory and write-source controls are Moore outputs.
// They are decoded from the state and the opcode (ir[7:4]). They are
// registered by computing them from the next state, so each output is valid
// in the same cycle as the state it belongs to.
//
// Optional build macro:
//   SEQ_SINGLE_STEP_EN - adds the 'step' input. A retiring instruction parks
//                        in IDLE. IDLE only leaves when run and step are both
//                        high, so one instruction executes per step pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   run          1 = execute, 0 = stop at the next instruction boundary
//   step         single-step pulse (only with SEQ_SINGLE_STEP_EN)
//   imem_data    instruction memory data at address pc (combinational)
//   alu_zero     ALU result is zero; sampled in EXECUTE
//   mem_ready    data memory has completed the current access
//   pc           program counter / instruction memory address
//   ir           latched instruction
//   imm          latched immediate / target byte
//   reg_addr_0   read register 0 (ir[1:0])
//   reg_addr_1   read register 1 (ir[3:2])
//   reg_addr_w   write register
//   reg_w_en     register file write strobe
//   mem_r_en     data memory read request
//   mem_w_en     data memory write request
//   sel_w_source write data source: 00 ALU, 01 memory, 10 link (pc)
//   busy         sequencer is not idle
//   retire_cnt   retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int unsigned CNT_W    = 16,
    parameter logic [7:0]  PC_RESET = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [7:0]       imem_data,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic [7:0]       pc,
    output logic [7:0]       ir,
    output logic [7:0]       imm,
    output logic [1:0]       reg_addr_0,
    output logic [1:0]       reg_addr_1,
    output logic [1:0]       reg_addr_w,
    output logic             reg_w_en,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic [1:0]       sel_w_source,
    output logic             busy,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_FETCH_IMM = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5
    } state_t;

    localparam logic [3:0] OP_J   = 4'h8;
    localparam logic [3:0] OP_JAL = 4'h9;
    localparam logic [3:0] OP_LW  = 4'hA;
    localparam logic [3:0] OP_SW  = 4'hB;
    localparam logic [3:0] OP_BEQ = 4'hC;
    localparam logic [3:0] OP_BNE = 4'hD;

    // Where a retiring instruction goes, and what lets IDLE start again.
`ifdef SEQ_SINGLE_STEP_EN
    localparam state_t RETIRE_TO = S_IDLE;
    logic start_ok;
    assign start_ok = run & step;
`else
    localparam state_t RETIRE_TO = S_FETCH;
    logic start_ok;
    assign start_ok = run;
`endif

    state_t     state;
    state_t     state_next;
    logic [7:0] pc_next;
    logic [7:0] ir_next;
    logic [7:0] imm_next;
    logic       retire;
    logic [3:0] op;
    logic [3:0] op_next;

    assign op      = ir[7:4];
    assign op_next = ir_next[7:4];

    // Opcodes 8, 9, C, D, E and F carry a second byte.
    function automatic logic is_two_byte(input logic [3:0] o);
        return (o >= 4'h8) && (o != OP_LW) && (o != OP_SW);
    endfunction

    // Next-state and datapath-register update.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        imm_next   = imm;
        retire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // The stop request is honoured only here, at an instruction boundary.
                if (!run) begin
                    state_next = S_IDLE;
                end else begin
                    ir_next    = imem_data;
                    pc_next    = pc + 8'd1;
                    state_next = is_two_byte(imem_data[7:4]) ? S_FETCH_IMM : S_EXECUTE;
                end
            end
            S_FETCH_IMM: begin
                imm_next   = imem_data;
                pc_next    = pc + 8'd1;
                state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                case (op)
                    OP_J, OP_JAL: begin
                        pc_next = imm;
                        retire  = 1'b1;
                    end
                    OP_BEQ: begin
                        if (alu_zero) begin
                            pc_next = imm;
                        end
                        retire = 1'b1;
                    end
                    OP_BNE: begin
                        if (!alu_zero) begin
                            pc_next = imm;
                        end
                        retire = 1'b1;
                    end
                    OP_LW, OP_SW: state_next = S_MEM;
                    default:      state_next = S_WRITEBACK;
                endcase
            end
            S_MEM: begin
                // No timeout: the access is held until memory answers.
                if (mem_ready) begin
                    if (op == OP_LW) begin
                        state_next = S_WRITEBACK;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            S_WRITEBACK: begin
                retire = 1'b1;
            end
            default: begin
                // Unused encodings 6 and 7 recover to IDLE.
                state_next = S_IDLE;
            end
        endcase
        if (retire) begin
            state_next = RETIRE_TO;
        end
    end

    // State, datapath registers and registered Moore strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pc           <= PC_RESET;
            ir           <= 8'h00;
            imm          <= 8'h00;
            retire_cnt   <= '0;
            reg_w_en     <= 1'b0;
            mem_r_en     <= 1'b0;
            mem_w_en     <= 1'b0;
            sel_w_source <= 2'b00;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
            imm   <= imm_next;
            if (retire) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
            // Strobes are decoded from the state being entered so they line
            // up with that state without a combinational output path.
            reg_w_en <= (state_next == S_WRITEBACK) ||
                        ((state_next == S_EXECUTE) && (op_next == OP_JAL));
            mem_r_en <= (state_next == S_MEM) && (op_next == OP_LW);
            mem_w_en <= (state_next == S_MEM) && (op_next == OP_SW);
            if ((state_next == S_EXECUTE) && (op_next == OP_JAL)) begin
                sel_w_source <= 2'b10;
            end else if ((state_next == S_WRITEBACK) && (op_next == OP_LW)) begin
                sel_w_source <= 2'b01;
            end else begin
                sel_w_source <= 2'b00;
            end
        end
    end

    assign busy       = (state != S_IDLE);
    assign reg_addr_0 = ir[1:0];
    assign reg_addr_1 = ir[3:2];

    // Write register: fixed r0 for ops without a register result, r3 as link.
    always_comb begin
        reg_addr_w = ir[3:2];
        case (op)
            4'h1, 4'h2, 4'h4, 4'h5, OP_SW, OP_BEQ, OP_BNE: reg_addr_w = 2'b00;
            OP_JAL:                                        reg_addr_w = 2'b11;
            default:                                       reg_addr_w = ir[3:2];
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Self-checking bench for cpu_sequencer. A behavioural model tracks each
// instruction as a cycle count since its fetch. The outputs are compared
// against the model on every falling clock edge. Directed scenarios pin the
// model with hand-computed values. Randomized programs and inputs follow.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic alu_zero = 1'b0;
    logic mem_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic step = 1'b1;
`endif
    logic [7:0]  imem [256];
    logic [7:0]  imem_data;
    logic [7:0]  pc, ir, imm;
    logic [1:0]  reg_addr_0, reg_addr_1, reg_addr_w, sel_w_source;
    logic        reg_w_en, mem_r_en, mem_w_en, busy;
    logic [15:0] retire_cnt;

    assign imem_data = imem[pc];

    cpu_sequencer #(.CNT_W(16), .PC_RESET(8'h00)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
`ifdef SEQ_SINGLE_STEP_EN
        .step         (step),
`endif
        .imem_data    (imem_data),
        .alu_zero     (alu_zero),
        .mem_ready    (mem_ready),
        .pc           (pc),
        .ir           (ir),
        .imm          (imm),
        .reg_addr_0   (reg_addr_0),
        .reg_addr_1   (reg_addr_1),
        .reg_addr_w   (reg_addr_w),
        .reg_w_en     (reg_w_en),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .sel_w_source (sel_w_source),
        .busy         (busy),
        .retire_cnt   (retire_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_k counts cycles since the fetch cycle of the current instruction.
    // m_mem_end records the cycle where a load saw mem_ready (-1 = not yet).
    bit          m_busy = 1'b0;
    int          m_k = 0;
    int          m_mem_end = -1;
    logic [7:0]  m_pc = 8'h00;
    logic [7:0]  m_ir = 8'h00;
    logic [7:0]  m_imm = 8'h00;
    logic [15:0] m_cnt = 16'h0000;

    function automatic bit two_byte(input logic [3:0] o);
        return (o >= 4'h8) && (o != 4'hA) && (o != 4'hB);
    endfunction

    task automatic model_step();
        bit         retire = 1'b0;
        logic [3:0] op = m_ir[7:4];
        int         ek = two_byte(m_ir[7:4]) ? 2 : 1;
        if (!m_busy) begin
            if (run) begin
                m_busy = 1'b1;
                m_k    = 0;
            end
        end else if (m_k == 0) begin
            if (!run) begin
                m_busy = 1'b0;
            end else begin
                m_ir      = imem[m_pc];
                m_pc      = m_pc + 8'd1;
                m_mem_end = -1;
                m_k       = 1;
            end
        end else if (two_byte(op) && m_k == 1) begin
            m_imm = imem[m_pc];
            m_pc  = m_pc + 8'd1;
            m_k   = 2;
        end else if (m_k == ek) begin
            case (op)
                4'h8, 4'h9: begin m_pc = m_imm; retire = 1'b1; end
                4'hC: begin if (alu_zero) m_pc = m_imm; retire = 1'b1; end
                4'hD: begin if (!alu_zero) m_pc = m_imm; retire = 1'b1; end
                default: m_k++;
            endcase
        end else begin
            if ((op == 4'hA || op == 4'hB) && m_mem_end < 0) begin
                if (mem_ready) begin
                    if (op == 4'hA) begin
                        m_mem_end = m_k;
                        m_k++;
                    end else begin
                        retire = 1'b1;
                    end
                end else begin
                    m_k++;
                end
            end else begin
                retire = 1'b1;
            end
        end
        if (retire) begin
            m_cnt = m_cnt + 16'd1;
            m_k   = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_busy = 1'b0; m_k = 0; m_mem_end = -1;
                m_pc = 8'h00; m_ir = 8'h00; m_imm = 8'h00; m_cnt = 16'h0000;
            end else begin
                model_step();
            end
        end
    end

    task automatic compare();
        logic [3:0] op = m_ir[7:4];
        int         ek = two_byte(m_ir[7:4]) ? 2 : 1;
        bit         e_jal, e_mem, e_wb;
        logic [1:0] e_sel, e_aw;
        e_jal = m_busy && op == 4'h9 && m_k == ek;
        e_mem = m_busy && (op == 4'hA || op == 4'hB) && m_k > ek && m_mem_end < 0;
        e_wb  = m_busy && (((op < 4'h8 || op >= 4'hE) && m_k == ek + 1) ||
                           (op == 4'hA && m_mem_end >= 0 && m_k == m_mem_end + 1));
        e_sel = e_jal ? 2'b10 : ((e_wb && op == 4'hA) ? 2'b01 : 2'b00);
        case (op)
            4'h1, 4'h2, 4'h4, 4'h5, 4'hB, 4'hC, 4'hD: e_aw = 2'b00;
            4'h9:    e_aw = 2'b11;
            default: e_aw = m_ir[3:2];
        endcase
        chk("pc",           32'(pc),           32'(m_pc));
        chk("ir",           32'(ir),           32'(m_ir));
        chk("imm",          32'(imm),          32'(m_imm));
        chk("busy",         32'(busy),         32'(m_busy));
        chk("retire_cnt",   32'(retire_cnt),   32'(m_cnt));
        chk("reg_w_en",     32'(reg_w_en),     32'(e_jal || e_wb));
        chk("mem_r_en",     32'(mem_r_en),     32'(e_mem && op == 4'hA));
        chk("mem_w_en",     32'(mem_w_en),     32'(e_mem && op == 4'hB));
        chk("sel_w_source", 32'(sel_w_source), 32'(e_sel));
        chk("reg_addr_w",   32'(reg_addr_w),   32'(e_aw));
        chk("reg_addr_0",   32'(reg_addr_0),   32'(m_ir[1:0]));
        chk("reg_addr_1",   32'(reg_addr_1),   32'(m_ir[3:2]));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) compare();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) imem[i] = v;
    endtask

    // Cycles until retire_cnt changes, bounded.
    task automatic wait_retire(output int cyc);
        logic [15:0] c0 = retire_cnt;
        cyc = 0;
        do begin
            tick(1);
            cyc++;
        end while (retire_cnt == c0 && cyc < 60);
        if (retire_cnt == c0) begin
            n_total++;
            $display("FAIL retire_timeout: got no retirement in %0d cycles, required one", cyc);
        end
    endtask

    initial begin
        int cyc;
        int hi;
        bit saw_w;
        fill(8'h00);
        tick(1);

        // Reset state, then ADD r1,r0 at pc 0
        do_reset();
        chk_en = 1'b1;
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_ir", 32'(ir), 32'h00);
        chk("rst_retire", 32'(retire_cnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_strobes", 32'({reg_w_en, mem_r_en, mem_w_en, sel_w_source}), 32'h0);
        fill(8'h14);
        run = 1'b1;
        tick(1); chk("add_busy", 32'(busy), 32'h1);
        tick(2); chk("add_wen", 32'(reg_w_en), 32'h1);
        chk("add_waddr", 32'(reg_addr_w), 32'h0);
        chk("add_pc", 32'(pc), 32'h01);
        tick(1); chk("add_retire", 32'(retire_cnt), 32'h1);
        wait_retire(cyc); chk("alu_latency", 32'(cyc), 32'd3);
        // run dropped mid-instruction: it still retires, then stops
        tick(1); run = 1'b0;
        tick(2); chk("stop_busy_fetch", 32'(busy), 32'h1);
        chk("stop_retire", 32'(retire_cnt), 32'h3);
        tick(1); chk("stop_busy_idle", 32'(busy), 32'h0);
        chk("stop_pc", 32'(pc), 32'h03);

        // LI r2, 0x5A
        do_reset();
        for (int i = 0; i < 256; i++) imem[i] = (i % 2 == 0) ? 8'hF8 : 8'h5A;
        run = 1'b1;
        tick(3); chk("li_imm", 32'(imm), 32'h5A);
        chk("li_waddr", 32'(reg_addr_w), 32'h2);
        chk("li_pc", 32'(pc), 32'h02);
        wait_retire(cyc);
        wait_retire(cyc); chk("li_latency", 32'(cyc), 32'd4);
        run = 1'b0; tick(2);

        // J 0x00 loop
        do_reset(); fill(8'h00); imem[0] = 8'h80; imem[1] = 8'h00;
        run = 1'b1;
        wait_retire(cyc);
        wait_retire(cyc); chk("j_latency", 32'(cyc), 32'd3);
        chk("j_pc", 32'(pc), 32'h00);
        run = 1'b0; tick(2);

        // LW with three wait cycles
        do_reset(); fill(8'h00); imem[0] = 8'hA4;
        run = 1'b1;
        tick(3);
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_r_en) hi++;
            if (i == 3) mem_ready = 1'b1;
            tick(1);
        end
        chk("lw_ren_cycles", 32'(hi), 32'd4);
        chk("lw_ren_off", 32'(mem_r_en), 32'h0);
        chk("lw_wb_wen", 32'(reg_w_en), 32'h1);
        chk("lw_wb_sel", 32'(sel_w_source), 32'h1);
        chk("lw_waddr", 32'(reg_addr_w), 32'h1);
        mem_ready = 1'b0; run = 1'b0;
        tick(1); chk("lw_retire", 32'(retire_cnt), 32'h1);
        tick(1);

        // SW with three wait cycles
        do_reset(); fill(8'h00); imem[0] = 8'hB4;
        run = 1'b1;
        tick(3);
        hi = 0; saw_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mem_w_en) hi++;
            if (reg_w_en) saw_w = 1'b1;
            if (i == 3) mem_ready = 1'b1;
            tick(1);
        end
        if (reg_w_en) saw_w = 1'b1;
        chk("sw_wen_cycles", 32'(hi), 32'd4);
        chk("sw_wen_off", 32'(mem_w_en), 32'h0);
        chk("sw_no_regw", 32'(saw_w), 32'h0);
        chk("sw_retire", 32'(retire_cnt), 32'h1);
        mem_ready = 1'b0; run = 1'b0; tick(2);

        // BEQ taken / not taken
        for (int t = 0; t < 2; t++) begin
            do_reset(); fill(8'h00); imem[0] = 8'hC0; imem[1] = 8'h40;
            alu_zero = (t == 0); run = 1'b1;
            tick(3); chk("beq_imm", 32'(imm), 32'h40);
            run = 1'b0;
            tick(1); chk("beq_pc", 32'(pc), (t == 0) ? 32'h40 : 32'h02);
            tick(1);
        end

        // JAL 0x20
        do_reset(); fill(8'h00); imem[0] = 8'h90; imem[1] = 8'h20;
        run = 1'b1;
        tick(3); chk("jal_wen", 32'(reg_w_en), 32'h1);
        chk("jal_waddr", 32'(reg_addr_w), 32'h3);
        chk("jal_sel", 32'(sel_w_source), 32'h2);
        run = 1'b0;
        tick(1); chk("jal_pc", 32'(pc), 32'h20);
        tick(1);

        // Two-byte op at 0xFF: immediate comes from 0x00
        do_reset(); fill(8'h00); imem[0] = 8'h80; imem[1] = 8'hFF; imem[255] = 8'hF4;
        run = 1'b1;
        tick(6); chk("wrap2_pc", 32'(pc), 32'h01);
        chk("wrap2_imm", 32'(imm), 32'h80);
        run = 1'b0; tick(3);

        // One-byte op at 0xFF
        do_reset(); fill(8'h00); imem[0] = 8'h80; imem[1] = 8'hFF; imem[255] = 8'h14;
        run = 1'b1;
        tick(5); chk("wrap1_pc", 32'(pc), 32'h00);
        chk("wrap1_ir", 32'(ir), 32'h14);
        run = 1'b0; tick(3);

        // Reset during a MEM wait
        do_reset(); fill(8'h14); imem[1] = 8'hA4;
        run = 1'b1;
        tick(6); chk("mrst_ren", 32'(mem_r_en), 32'h1);
        chk("mrst_retire_pre", 32'(retire_cnt), 32'h1);
        rst_n = 1'b0; run = 1'b0;
        tick(1); chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_ren_off", 32'(mem_r_en), 32'h0);
        chk("mrst_pc", 32'(pc), 32'h00);
        chk("mrst_retire", 32'(retire_cnt), 32'h0);
        rst_n = 1'b1;

        // Randomized programs and inputs
        for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
        for (int c = 0; c < 4000; c++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            run       = ($urandom_range(0, 9) != 0);
            alu_zero  = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) imem[$urandom_range(0, 255)] = 8'($urandom);
            tick(1);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
